// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// Data side has priority; a one-cycle completion mask alternates held requests; stuck transactions time out.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          iready,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dready,
    output logic          err,
    output logic [1:0]    owner,
    output logic          memreq,
    output logic          memwe,
    output logic [AW-1:0] memaddr,
    output logic [DW-1:0] memwdata,
    input  logic [DW-1:0] memrdata,
    input  logic          memack
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_I);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          TO_EN    = (TIMEOUT != 0);

    // Encoding doubles as the owner code driven on the owner output.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_IBUSY = 2'b01,
        S_DBUSY = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_dreq_m;
    logic            w_ireq_m;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_done;
    logic            w_timeout;
    logic            w_busy;

    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_irdata;
    logic [DW-1:0]   r_drdata;
    logic            r_memreq;
    logic            r_memwe;
    logic            r_iready;
    logic            r_dready;
    logic            r_err;

    // A requester whose ready is high this cycle is treated as idle.
    assign w_dreq_m = dreq & ~r_dready;
    assign w_ireq_m = ireq & ~r_iready;
    assign w_busy   = (r_state != S_IDLE);

    // Next-state, grant and completion decode.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dreq_m) begin
                    w_grant_d    = 1'b1;
                    w_next_state = S_DBUSY;
                end else if (w_ireq_m) begin
                    w_grant_i    = 1'b1;
                    w_next_state = S_IBUSY;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_IBUSY, S_DBUSY: begin
                if (memack) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (TO_EN && (r_cnt == CNT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched request fields and memory-side control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= {AW{1'b0}};
            r_wdata  <= {DW{1'b0}};
            r_memreq <= 1'b0;
            r_memwe  <= 1'b0;
        end else begin
            r_memreq <= (w_next_state != S_IDLE);
            if (w_grant_d) begin
                r_addr  <= daddr;
                r_wdata <= dwdata;
                r_memwe <= dwe;
            end else if (w_grant_i) begin
                r_addr  <= iaddr;
                r_memwe <= 1'b0;
            end else if (w_next_state == S_IDLE) begin
                r_memwe <= 1'b0;
            end else begin
                r_memwe <= r_memwe;
            end
        end
    end

    // Wait counter: zeroed on grant, counts BUSY cycles without memack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_grant_d || w_grant_i) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_busy && !memack) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Read data capture; a store or an aborted transaction leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irdata <= {DW{1'b0}};
            r_drdata <= {DW{1'b0}};
        end else begin
            if ((r_state == S_IBUSY) && memack) begin
                r_irdata <= memrdata;
            end
            if ((r_state == S_DBUSY) && memack && !r_memwe) begin
                r_drdata <= memrdata;
            end
        end
    end

    // One-cycle completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iready <= 1'b0;
            r_dready <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_iready <= (r_state == S_IBUSY) && (w_done || w_timeout);
            r_dready <= (r_state == S_DBUSY) && (w_done || w_timeout);
            r_err    <= w_timeout;
        end
    end

    assign owner    = r_state;
    assign memreq   = r_memreq;
    assign memwe    = r_memwe;
    assign memaddr  = r_addr;
    assign memwdata = r_wdata;
    assign irdata   = r_irdata;
    assign drdata   = r_drdata;
    assign iready   = r_iready;
    assign dready   = r_dready;
    assign err      = r_err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single unified memory port between the pipeline's instruction-fetch requester (F stage) and its load/store requester (M stage). Each requester holds a request until it receives a one-cycle ready pulse. The pipeline uses a requester's pending request, not yet acknowledged, as a stall condition alongside the hazard unit's stalls. The arbiter serialises transactions, gives the data port priority with a completion mask for fairness, and aborts transactions the memory never acknowledges.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the timeout
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ireq  in  1  fetch request; held with iaddr stable until iready
- iaddr  in  AW  fetch address (pcF)
- irdata  out  DW  last fetched instruction word
- iready  out  1  one-cycle pulse: fetch transaction complete
- dreq  in  1  data request; held with dwe/daddr/dwdata stable until dready
- dwe  in  1  1 = store, 0 = load
- daddr  in  AW  data address (aluoutM)
- dwdata  in  DW  store data (writedataM)
- drdata  out  DW  last loaded word
- dready  out  1  one-cycle pulse: data transaction complete
- err  out  1  one-cycle pulse, coincident with the ready pulse, when the transaction timed out
- owner  out  2  00 none, 01 fetch, 10 data (current BUSY owner)
- memreq  out  1  memory request; held until memack
- memwe  out  1  memory write enable
- memaddr  out  AW  memory address
- memwdata  out  DW  memory write data
- memrdata  in  DW  memory read data; valid when memack=1
- memack  in  1  memory completion; ignored while memreq=0

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE arbitration uses masked requests: a port whose ready output is high this cycle has its req ignored.
- IDLE, masked dreq=1: latch dwe/daddr/dwdata, go to DBUSY.
- IDLE, masked dreq=0 and masked ireq=1: latch iaddr with we=0, go to IBUSY.
- IDLE otherwise: stay in IDLE.
- Data has priority. The mask causes two continuously held requests to alternate D, I, D, I.
- BUSY states drive memreq=1 and memwe/memaddr/memwdata from the latched registers. These outputs stay constant for the whole transaction. owner reflects the state.
- In IDLE: memreq=0, memwe=0, owner=00. memaddr/memwdata hold their last latched values.
- BUSY with memack=1:
  - For a fetch, irdata<=memrdata.
  - For a load, drdata<=memrdata.
  - For a store, drdata is unchanged.
  - The owner's ready<=1, then go to IDLE.
- Wait counter: cleared on BUSY entry and incremented on each BUSY cycle without memack. If TIMEOUT≠0 and the TIMEOUT-th BUSY cycle passes with no memack, the owner's ready<=1 and err<=1, rdata is unchanged, and the state goes to IDLE. A memack on that same cycle takes precedence and completes the transaction normally (err=0).
- ready and err are registered and high for exactly one cycle. iready and dready are never high together.
- Address, data, and counter widths come from the parameters. The wait counter is at least 1 bit wide and wide enough to hold TIMEOUT.
- Reset (any state, including mid-transaction) forces the following, effective after the edge: state=IDLE; memreq=memwe=0; memaddr=memwdata=0; irdata=drdata=0; iready=dready=err=0; owner=00; counter=0. An aborted transaction produces no ready pulse.

## Timing
- A request is sampled in IDLE at cycle 0. memreq is high from cycle 1.
- memack arrives at cycle k≥1 (memack in cycle 1 is legal). The ready pulse and return to IDLE occur in cycle k+1.
- Minimum transaction: 2 cycles from request sample to ready.
- Minimum gap between transactions: IDLE occupies 1 cycle, because the ready cycle is also the next arbitration cycle. A new memreq rises in cycle k+2.
- Timeout: memreq is high for exactly TIMEOUT cycles, then ready+err follow in the next cycle.
- A requester drops or changes req in the cycle its ready is high. The masking rule makes the value in that cycle irrelevant.

## Test plan
- Fetch, 3-cycle memory. Stimulus: ireq=1 with iaddr=0x00000040 at cycle 0; memack at cycle 3 with memrdata=0x8C010004. Required: memreq=1, memaddr=0x40, memwe=0, owner=01 in cycles 1–3; iready=1 and irdata=0x8C010004 in cycle 4; owner=00 in cycle 4.
- Simultaneous requests, both held, 1-cycle ack. Required: owner sequence 10, 01, 10, 01 across four transactions; each ready pulses exactly once per transaction; no cycle has iready and dready both high.
- Store. Stimulus: dreq=1, dwe=1, daddr=0x54, dwdata=0xDEADBEEF; drdata preloaded to 0x11111111 by a prior load. Required: memwe=1, memaddr=0x54, memwdata=0xDEADBEEF until ack; dready pulses; drdata remains 0x11111111.
- Timeout (TIMEOUT=4). Stimulus: dreq=1 with a load; memack held 0. Required: memreq=1 for exactly cycles 1–4; dready=1 and err=1 in cycle 5; drdata unchanged. Repeat with memack in cycle 4: err=0 and the data is captured.
- Reset mid-transaction. Stimulus: reset=1 for one cycle during DBUSY at cycle 2. Required: memreq=0, owner=00, all data outputs 0 in cycle 3; no dready pulse; a fresh ireq afterward completes normally.
- Ready-cycle masking. Stimulus: dreq held high through and after its dready cycle, with ireq=0. Required: no new grant in the dready cycle; a new DBUSY starts only if dreq is still high in the following IDLE cycle.
